// File: rtl/crush_csr_pkg.sv
// Shared definitions for the crush machine-mode CSR file and trap sequencer:
// CSR addresses, status/enable/pending bit positions, cause codes and the
// CSR operation encodings with their read-modify-write rule.
package crush_csr_pkg;

  localparam int unsigned XLEN = 32;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  // Bit positions
  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MSTATUS_MPP_LSB  = 11;
  localparam int unsigned MIE_MTIE_BIT     = 7;
  localparam int unsigned MIE_MEIE_BIT     = 11;
  localparam int unsigned MIP_MTIP_BIT     = 7;
  localparam int unsigned MIP_MEIP_BIT     = 11;

  // Cause codes
  localparam logic [3:0] CAUSE_MTI   = 4'd7;
  localparam logic [3:0] CAUSE_MEI   = 4'd11;
  localparam logic [3:0] EXC_ILLEGAL = 4'd2;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  // Value a CSR instruction would write, given the old CSR contents
  function automatic logic [XLEN-1:0] csr_apply(input csr_op_e         op,
                                                input logic [XLEN-1:0] old_val,
                                                input logic [XLEN-1:0] wdata);
    case (op)
      CSR_OP_RW: csr_apply = wdata;
      CSR_OP_RS: csr_apply = old_val | wdata;
      CSR_OP_RC: csr_apply = old_val & ~wdata;
      default:   csr_apply = old_val;
    endcase
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchroniser for an asynchronous interrupt level.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, clears both flops
//   d_i    : asynchronous level in
//   q_o    : synchronised level out (two cycles of latency)
module irq_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/csr_trap.sv
// Machine-mode CSR file and trap sequencer for the crush CPU.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   mtip_i, meip_i         : timer / external interrupt levels
//   timer_irq_en_o         : mstatus.MIE & mie.MTIE back to the machine timer
//   csr_valid_i/we_i/op_i/addr_i/wdata_i : retiring CSR instruction
//   csr_rdata_o, csr_illegal_o           : combinational old value / illegal flag
//   retire_valid_i, retire_npc_i         : instruction boundary, next PC
//   exc_valid_i, exc_cause_i, exc_pc_i   : synchronous exception
//   mret_i                 : mret retiring
//   redirect_o, redirect_pc_o : registered one-cycle fetch redirect
module csr_trap
  import crush_csr_pkg::*;
#(
  parameter bit          SYNC_MEIP = 1'b1,
  parameter logic [31:0] HART_ID   = 32'd0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            mtip_i,
  input  logic            meip_i,
  output logic            timer_irq_en_o,
  input  logic            csr_valid_i,
  input  logic            csr_we_i,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  input  logic            retire_valid_i,
  input  logic [XLEN-1:0] retire_npc_i,
  input  logic            exc_valid_i,
  input  logic [3:0]      exc_cause_i,
  input  logic [XLEN-1:0] exc_pc_i,
  input  logic            mret_i,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  logic meip_s;

  if (SYNC_MEIP) begin : g_meip_sync
    irq_sync u_meip_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (meip_i),
      .q_o    (meip_s)
    );
  end else begin : g_meip_raw
    assign meip_s = meip_i;
  end

  logic            mst_mie_q, mst_mie_d;
  logic            mst_mpie_q, mst_mpie_d;
  logic            mie_mtie_q, mie_mtie_d;
  logic            mie_meie_q, mie_meie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  logic [XLEN-1:0] rdata_c;
  logic            mapped_c;
  logic            illegal_c;
  logic [XLEN-1:0] wval_c;
  logic            commit_c;
  logic            irq_mei_c, irq_mti_c, irq_take_c;

  // CSR read mux and address decode
  always_comb begin
    rdata_c  = '0;
    mapped_c = 1'b1;
    case (csr_addr_i)
      CSR_MSTATUS: begin
        rdata_c[MSTATUS_MPP_LSB +: 2] = 2'b11;
        rdata_c[MSTATUS_MIE_BIT]      = mst_mie_q;
        rdata_c[MSTATUS_MPIE_BIT]     = mst_mpie_q;
      end
      CSR_MIE: begin
        rdata_c[MIE_MTIE_BIT] = mie_mtie_q;
        rdata_c[MIE_MEIE_BIT] = mie_meie_q;
      end
      CSR_MTVEC:    rdata_c = mtvec_q;
      CSR_MSCRATCH: rdata_c = mscratch_q;
      CSR_MEPC:     rdata_c = mepc_q;
      CSR_MCAUSE:   rdata_c = mcause_q;
      CSR_MIP: begin
        rdata_c[MIP_MTIP_BIT] = mtip_i;
        rdata_c[MIP_MEIP_BIT] = meip_s;
      end
      CSR_MHARTID:  rdata_c = HART_ID;
      default:      mapped_c = 1'b0;
    endcase
  end

  // Addresses with [11:10]==2'b11 are read-only
  assign illegal_c = csr_valid_i &
                     (~mapped_c | (csr_we_i & (csr_addr_i[11:10] == 2'b11)));
  assign wval_c    = csr_apply(csr_op_e'(csr_op_i), rdata_c, csr_wdata_i);
  assign commit_c  = csr_valid_i & csr_we_i & ~illegal_c & ~exc_valid_i;

  assign irq_mei_c  = mie_meie_q & meip_s;
  assign irq_mti_c  = mie_mtie_q & mtip_i;
  assign irq_take_c = retire_valid_i & mst_mie_q & (irq_mei_c | irq_mti_c);

  // Next state: CSR write first, then trap/mret fields override it
  always_comb begin
    mst_mie_d     = mst_mie_q;
    mst_mpie_d    = mst_mpie_q;
    mie_mtie_d    = mie_mtie_q;
    mie_meie_d    = mie_meie_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;

    if (commit_c) begin
      case (csr_addr_i)
        CSR_MSTATUS: begin
          mst_mie_d  = wval_c[MSTATUS_MIE_BIT];
          mst_mpie_d = wval_c[MSTATUS_MPIE_BIT];
        end
        CSR_MIE: begin
          mie_mtie_d = wval_c[MIE_MTIE_BIT];
          mie_meie_d = wval_c[MIE_MEIE_BIT];
        end
        CSR_MTVEC:    mtvec_d    = wval_c & ~32'h3;
        CSR_MSCRATCH: mscratch_d = wval_c;
        CSR_MEPC:     mepc_d     = wval_c & ~32'h3;
        CSR_MCAUSE:   mcause_d   = wval_c;
        default: ;
      endcase
    end

    if (exc_valid_i || irq_take_c) begin
      if (exc_valid_i) begin
        mepc_d   = exc_pc_i & ~32'h3;
        mcause_d = {28'b0, exc_cause_i};
      end else begin
        mepc_d   = retire_npc_i & ~32'h3;
        mcause_d = {1'b1, 27'b0, (irq_mei_c ? CAUSE_MEI : CAUSE_MTI)};
      end
      mst_mpie_d    = mst_mie_q;
      mst_mie_d     = 1'b0;
      redirect_d    = 1'b1;
      redirect_pc_d = mtvec_q;
    end else if (mret_i) begin
      mst_mie_d     = mst_mpie_q;
      mst_mpie_d    = 1'b1;
      redirect_d    = 1'b1;
      redirect_pc_d = mepc_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mst_mie_q     <= 1'b0;
      mst_mpie_q    <= 1'b0;
      mie_mtie_q    <= 1'b0;
      mie_meie_q    <= 1'b0;
      mtvec_q       <= '0;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      mst_mie_q     <= mst_mie_d;
      mst_mpie_q    <= mst_mpie_d;
      mie_mtie_q    <= mie_mtie_d;
      mie_meie_q    <= mie_meie_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign csr_rdata_o    = rdata_c;
  assign csr_illegal_o  = illegal_c;
  assign timer_irq_en_o = mst_mie_q & mie_mtie_q;
  assign redirect_o     = redirect_q;
  assign redirect_pc_o  = redirect_pc_q;

endmodule

// File: doc/csr_trap.md
Name: csr_trap

Overview:
- Machine-mode CSR file and trap sequencer for the crush CPU. It sits directly downstream of the machine timer.
- It consumes the timer's level interrupt, returns the timer's interrupt_enable, and adds a synchronised external interrupt.
- It handles CSR instructions, exception/interrupt trap entry and mret, and sends PC redirects to the fetch stage.

Parameters:
- SYNC_MEIP, 1, 1 = meip_i passes through a 2-flop synchroniser; 0 = meip_i is used directly.
- HART_ID, 0, value read from mhartid.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- mtip_i  in  1  timer interrupt level from the machine timer
- meip_i  in  1  external interrupt level (asynchronous if SYNC_MEIP=1)
- timer_irq_en_o  out  1  mstatus.MIE & mie.MTIE; drives the timer's interrupt_enable
- csr_valid_i  in  1  CSR instruction retiring this cycle
- csr_we_i  in  1  write intended (core clears it for RS/RC with rs1=x0)
- csr_op_i  in  2  01=RW, 10=RS, 11=RC
- csr_addr_i  in  12  CSR address
- csr_wdata_i  in  32  rs1 value or zimm
- csr_rdata_o  out  32  old CSR value, combinational
- csr_illegal_o  out  1  combinational; the core converts it to exception cause 2
- retire_valid_i  in  1  instruction boundary this cycle
- retire_npc_i  in  32  PC of the next instruction
- exc_valid_i  in  1  synchronous exception; mutually exclusive with retire_valid_i
- exc_cause_i  in  4  exception code
- exc_pc_i  in  32  faulting PC
- mret_i  in  1  mret retiring
- redirect_o  out  1  one-cycle pulse
- redirect_pc_o  out  32  redirect target

Behaviour:
- Reset (async assert, sync release): mstatus.MIE=0, MPIE=0. mie, mtvec, mscratch, mepc and mcause are 0. redirect_o=0, redirect_pc_o=0. Synchroniser flops are 0.
- CSR map:
  - mstatus 0x300: MIE bit3, MPIE bit7, MPP[12:11] read 2'b11; all other bits read 0.
  - mie 0x304: MTIE bit7, MEIE bit11.
  - mtvec 0x305: direct mode only; bits[1:0] read 0.
  - mscratch 0x340: full 32 bits.
  - mepc 0x341: bits[1:0] read 0.
  - mcause 0x342: full 32 bits.
  - mip 0x344: MTIP bit7 = mtip_i, MEIP bit11 = synchronised meip; read-only, writes ignored.
  - mhartid 0xF14: reads HART_ID.
- csr_illegal_o is high when csr_valid_i is high and either:
  - the address is unmapped, or
  - csr_we_i is high and csr_addr_i[11:10]==2'b11.
- An illegal access causes no state change.
- CSR write value: RW = wdata; RS = old | wdata; RC = old & ~wdata. The write commits on the clock edge when csr_valid_i & csr_we_i & !illegal & !exc_valid_i.
- Interrupt pending: int_pend = MIE & ((MEIE & meip_s) | (MTIE & mtip_i)), evaluated from registered state.
- Interrupt take: an interrupt is taken only when retire_valid_i & int_pend. Without retire_valid_i the interrupt stays pending with no timeout.
- Priority within one cycle: exception > interrupt > mret. Among interrupts, MEI (cause 11) > MTI (cause 7).
- Trap entry, all on the same edge:
  - mepc = exc_pc_i (exception) or retire_npc_i (interrupt).
  - mcause = {1'b0, 27'b0, exc_cause_i} for an exception, or {1'b1, 31'dN} for an interrupt.
  - MPIE = MIE; MIE = 0.
  - Next cycle: redirect_o=1, redirect_pc_o = {mtvec[31:2], 2'b00}.
- A CSR write retiring in the same cycle as an interrupt take is committed first. Trap field updates (mepc, mcause, MIE, MPIE) then override it.
- mret, when not pre-empted: MIE = MPIE, MPIE = 1. Next cycle: redirect_o=1, redirect_pc_o = mepc (old value).
- mret together with a taken interrupt: the interrupt wins, and mepc = retire_npc_i.
- Redirect: registered, exactly one cycle of latency, one cycle wide. Back-to-back events produce back-to-back pulses.
- Reset mid-redirect: the pulse is dropped immediately (async reset).
- timer_irq_en_o is a registered-state AND; it updates the cycle after any mstatus/mie write or trap entry.

Decomposition:
- Package crush_csr_pkg holds:
  - CSR address localparams
  - mstatus/mie/mip bit indices
  - interrupt cause codes (MTI=7, MEI=11)
  - exception code for illegal instruction (2)
  - csr_op encodings
- Sub-module irq_sync: 2-flop synchroniser with async active-low reset. Instantiated for meip when SYNC_MEIP=1.

Test Plan:
1. Write mtvec=0x0000_1003 (RW) -> read returns 0x0000_1000. Then RS mstatus with 0x8 -> MIE=1; mstatus reads 0x0000_1808.
2. Set mie.MTIE, MIE=1, raise mtip_i with retire_valid_i=1 and retire_npc_i=0x200 -> next cycle redirect_o=1, redirect_pc_o=0x1000; mepc=0x200, mcause=0x8000_0007, MIE=0, MPIE=1; timer_irq_en_o drops.
3. mtip_i and meip_i both high with both enabled, retire_valid_i=1 -> mcause=0x8000_000B. Then mret -> redirect_pc_o=mepc, MIE=1, MPIE=1.
4. exc_valid_i=1 with cause 3, exc_pc_i=0x44, mtip pending and enabled, CSR write mscratch=5 in the same cycle -> mcause=3, mepc=0x44, mscratch unchanged.
5. CSR RW to 0xF14 with we=1 -> csr_illegal_o=1, no state change. Read 0x7C0 -> illegal. RS to mip with we=0 -> legal, returns the live MTIP/MEIP bits.
6. Pending interrupt while retire_valid_i=0 for 5 cycles -> no redirect; taken on the first retire. Then assert rst_ni low while redirect_o=1 -> redirect_o=0 immediately and all CSRs return to reset values.
